// File: rtl/tea_pkg.sv
// Shared definitions for the TEA block engine: constants, FSM states, field
// packing and the Feistel round function.
package tea_pkg;

   localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      H0   = 2'd1,
      H1   = 2'd2,
      DONE = 2'd3
   } tea_state_e;

   // The first field of a packed struct is its MSB, which matches the port packing.
   typedef struct packed {
      logic [31:0] v0;
      logic [31:0] v1;
   } tea_block_t;

   typedef struct packed {
      logic [31:0] k0;
      logic [31:0] k1;
      logic [31:0] k2;
      logic [31:0] k3;
   } tea_key_t;

   function automatic logic [31:0] tea_f(input logic [31:0] x,
                                         input logic [31:0] s,
                                         input logic [31:0] ka,
                                         input logic [31:0] kb);
      return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
   endfunction

endpackage

// File: rtl/tea_half_round.sv
// One TEA half-round. It adds F to the destination word when encrypting and
// subtracts F from it when decrypting.
module tea_half_round
   import tea_pkg::*;
(
   input  logic [31:0] v_src,
   input  logic [31:0] v_dst,
   input  logic [31:0] sum,
   input  logic [31:0] ka,
   input  logic [31:0] kb,
   input  logic        mode,
   output logic [31:0] v_dst_next
);

   logic [31:0] f_val;

   assign f_val      = tea_f(v_src, sum, ka, kb);
   assign v_dst_next = (mode == MODE_DEC) ? (v_dst - f_val) : (v_dst + f_val);

endmodule

// File: rtl/tea_block_engine.sv
// Iterative TEA encrypt/decrypt engine. It completes one half-round per clock
// and moves blocks in and out over valid/ready handshakes.
module tea_block_engine
   import tea_pkg::*;
#(
   parameter int          ROUNDS = 32,
   parameter logic [31:0] DELTA  = DELTA_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [63:0]  in_block,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_block,
   output logic         out_mode,
   output logic         busy
);

   localparam int          CNT_W    = $clog2(ROUNDS + 1);
   localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);

   tea_state_e       state, state_next;
   logic [CNT_W-1:0] round_cnt;
   logic [31:0]      sum;
   logic [31:0]      v0, v1;
   tea_key_t         key;
   logic             mode;

   logic             accept;
   logic             last_round;
   logic             upd_v0;
   logic [31:0]      hr_src, hr_dst, hr_ka, hr_kb, hr_out;
   logic [31:0]      v0_next, v1_next;
   tea_block_t       in_fields;

   assign in_fields  = tea_block_t'(in_block);
   assign last_round = (round_cnt == CNT_W'(ROUNDS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = H0;
            end
         end
         H0:      state_next = H1;
         H1:      state_next = last_round ? DONE : H0;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Encrypt updates v0 then v1. Decrypt updates v1 then v0, and uses the key pairs in reverse order.
   assign upd_v0  = (state == H0) == (mode == MODE_ENC);
   assign hr_src  = upd_v0 ? v1 : v0;
   assign hr_dst  = upd_v0 ? v0 : v1;
   assign hr_ka   = upd_v0 ? key.k0 : key.k2;
   assign hr_kb   = upd_v0 ? key.k1 : key.k3;
   assign v0_next = upd_v0 ? hr_out : v0;
   assign v1_next = upd_v0 ? v1 : hr_out;

   tea_half_round u_half_round (
      .v_src      (hr_src),
      .v_dst      (hr_dst),
      .sum        (sum),
      .ka         (hr_ka),
      .kb         (hr_kb),
      .mode       (mode),
      .v_dst_next (hr_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every register is cleared on reset. An aborted block then leaves no key or data behind.
      if (reset) begin
         round_cnt <= '0;
         sum       <= '0;
         v0        <= '0;
         v1        <= '0;
         key       <= '0;
         mode      <= MODE_ENC;
         out_block <= '0;
         out_mode  <= MODE_ENC;
      end else begin
         // NOTE: non-blocking assignments, so every register samples its pre-edge value.
         unique case (state)
            IDLE: begin
               if (accept) begin
                  v0        <= in_fields.v0;
                  v1        <= in_fields.v1;
                  key       <= tea_key_t'(in_key);
                  mode      <= in_mode;
                  sum       <= (in_mode == MODE_DEC) ? SUM_INIT : DELTA;
                  round_cnt <= '0;
               end
            end
            H0: begin
               v0 <= v0_next;
               v1 <= v1_next;
            end
            H1: begin
               v0        <= v0_next;
               v1        <= v1_next;
               sum       <= (mode == MODE_DEC) ? (sum - DELTA) : (sum + DELTA);
               round_cnt <= round_cnt + CNT_W'(1);
               if (last_round) begin
                  out_block <= {v0_next, v1_next};
                  out_mode  <= mode;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tea_block_engine.sv
// Self-checking bench for tea_block_engine. It drives four instances, one each
// for ROUNDS = 1, 8, 32 and 64, and compares them against a textbook TEA model.
module tb_tea_block_engine;

   localparam int          N_DUT    = 4;
   localparam int          MAIN     = 2;
   localparam logic [31:0] DELTA    = 32'h9E3779B9;
   localparam logic [63:0] ZERO_CT  = 64'h41EA3A0A_94BAA940;
   localparam int          N_RANDOM = 50;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid  [N_DUT];
   logic         in_ready  [N_DUT];
   logic         in_mode   [N_DUT];
   logic [63:0]  in_block  [N_DUT];
   logic [127:0] in_key    [N_DUT];
   logic         out_valid [N_DUT];
   logic         out_ready [N_DUT];
   logic [63:0]  out_block [N_DUT];
   logic         out_mode  [N_DUT];
   logic         busy      [N_DUT];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      tea_block_engine #(
         .ROUNDS (g == 0 ? 1 : g == 1 ? 8 : g == 2 ? 32 : 64)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_mode   (in_mode[g]),
         .in_block  (in_block[g]),
         .in_key    (in_key[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_block (out_block[g]),
         .out_mode  (out_mode[g]),
         .busy      (busy[g])
      );
   end

   function automatic int rounds_of(input int idx);
      case (idx)
         0:       return 1;
         1:       return 8;
         2:       return 32;
         default: return 64;
      endcase
   endfunction

   // Textbook TEA: the encrypt loop adds DELTA to sum before each cycle, and decrypt undoes it in reverse order.
   function automatic logic [63:0] tea_model(input logic dec, input logic [63:0] blk,
                                             input logic [127:0] key, input int rounds);
      logic [31:0] y, z, s, k0, k1, k2, k3;
      y  = blk[63:32];
      z  = blk[31:0];
      k0 = key[127:96];
      k1 = key[95:64];
      k2 = key[63:32];
      k3 = key[31:0];
      if (!dec) begin
         s = 32'h0;
         repeat (rounds) begin
            s = s + DELTA;
            y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
         end
      end else begin
         s = DELTA * 32'(rounds);
         repeat (rounds) begin
            z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
            y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            s = s - DELTA;
         end
      end
      return {y, z};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Called at a negedge. It returns at the negedge that follows the accept edge,
   // after scrambling the inputs so that a late capture would show up.
   task automatic accept_block(input int idx, input logic mode, input logic [63:0] blk,
                               input logic [127:0] key);
      int waited = 0;
      while (!in_ready[idx] && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready[idx]) check($sformatf("in_ready timeout dut%0d", idx), 64'd0, 64'd1);
      in_valid[idx] = 1'b1;
      in_mode[idx]  = mode;
      in_block[idx] = blk;
      in_key[idx]   = key;
      @(posedge clk);
      @(negedge clk);
      in_valid[idx] = 1'b0;
      in_mode[idx]  = ~mode;
      in_block[idx] = ~blk;
      in_key[idx]   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_out(input int idx, output int lat);
      lat = 0;
      while (!out_valid[idx] && lat < 300) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!out_valid[idx]) check($sformatf("out_valid timeout dut%0d", idx), 64'd0, 64'd1);
   endtask

   task automatic run_block(input int idx, input logic mode, input logic [63:0] blk,
                            input logic [127:0] key, output logic [63:0] res,
                            output logic res_mode, output int lat);
      accept_block(idx, mode, blk, key);
      wait_out(idx, lat);
      res           = out_block[idx];
      res_mode      = out_mode[idx];
      out_ready[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[idx] = 1'b0;
   endtask

   typedef struct {
      logic         mode;
      logic [63:0]  blk;
      logic [127:0] key;
      logic [63:0]  exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [63:0]  res, ct, blk, held;
      logic [127:0] key;
      logic         res_mode, still_low;
      int           lat;

      for (int i = 0; i < N_DUT; i++) begin
         in_valid[i]  = 1'b0;
         in_mode[i]   = 1'b0;
         in_block[i]  = '0;
         in_key[i]    = '0;
         out_ready[i] = 1'b0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < N_DUT; i++) begin
         check($sformatf("reset in_ready dut%0d", i), 64'(in_ready[i]), 64'd1);
         check($sformatf("reset out_valid dut%0d", i), 64'(out_valid[i]), 64'd0);
         check($sformatf("reset busy dut%0d", i), 64'(busy[i]), 64'd0);
         check($sformatf("reset out_block dut%0d", i), out_block[i], 64'd0);
         check($sformatf("reset out_mode dut%0d", i), 64'(out_mode[i]), 64'd0);
      end
      reset = 1'b0;

      vecs[0] = '{1'b0, 64'h0, 128'h0, ZERO_CT};
      vecs[1] = '{1'b1, ZERO_CT, 128'h0, 64'h0};
      vecs[2] = '{1'b0, 64'h01234567_89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 64'h0};
      vecs[3] = '{1'b1, 64'hFFFFFFFF_FFFFFFFF, {128{1'b1}}, 64'h0};
      vecs[4] = '{1'b0, 64'h80000000_00000001, 128'h80000000_00000001_7FFFFFFF_FFFFFFFE, 64'h0};
      vecs[5] = '{1'b1, 64'hDEADBEEF_CAFEF00D, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 64'h0};
      for (int i = 2; i < 6; i++) vecs[i].exp = tea_model(vecs[i].mode, vecs[i].blk, vecs[i].key, 32);

      // The first vector is offered on the edge right after reset is released.
      for (int i = 0; i < 6; i++) begin
         run_block(MAIN, vecs[i].mode, vecs[i].blk, vecs[i].key, res, res_mode, lat);
         check($sformatf("vec%0d block", i), res, vecs[i].exp);
         check($sformatf("vec%0d mode", i), 64'(res_mode), 64'(vecs[i].mode));
         check($sformatf("vec%0d latency", i), 64'(lat), 64'd64);
      end

      for (int d = 0; d < N_DUT; d++) begin
         for (int n = 0; n < N_RANDOM; n++) begin
            blk = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_block(d, 1'b0, blk, key, ct, res_mode, lat);
            check($sformatf("rand enc dut%0d #%0d", d, n), ct, tea_model(1'b0, blk, key, rounds_of(d)));
            if (n == 0) check($sformatf("rand latency dut%0d", d), 64'(lat), 64'(2 * rounds_of(d)));
            run_block(d, 1'b1, ct, key, res, res_mode, lat);
            check($sformatf("rand roundtrip dut%0d #%0d", d, n), res, blk);
            check($sformatf("rand dec mode dut%0d #%0d", d, n), 64'(res_mode), 64'd1);
         end
      end

      // Back-pressure: hold DONE for 10 cycles and offer a competing block the whole time.
      accept_block(MAIN, 1'b0, 64'h0, 128'h0);
      wait_out(MAIN, lat);
      held = out_block[MAIN];
      check("bp result", held, ZERO_CT);
      in_valid[MAIN] = 1'b1;
      in_block[MAIN] = {$urandom, $urandom};
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp out_valid c%0d", c), 64'(out_valid[MAIN]), 64'd1);
         check($sformatf("bp out_block c%0d", c), out_block[MAIN], ZERO_CT);
         check($sformatf("bp in_ready c%0d", c), 64'(in_ready[MAIN]), 64'd0);
      end
      out_ready[MAIN] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[MAIN] = 1'b0;
      in_valid[MAIN]  = 1'b0;
      check("bp release out_valid", 64'(out_valid[MAIN]), 64'd0);
      check("bp release in_ready", 64'(in_ready[MAIN]), 64'd1);
      check("bp no accept on handshake", 64'(busy[MAIN]), 64'd0);
      check("bp out_block hold", out_block[MAIN], ZERO_CT);

      // Reset mid-operation: assert reset between edges during round 5.
      accept_block(MAIN, 1'b0, vecs[2].blk, vecs[2].key);
      repeat (8) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset out_valid", 64'(out_valid[MAIN]), 64'd0);
      check("midreset in_ready", 64'(in_ready[MAIN]), 64'd1);
      check("midreset busy", 64'(busy[MAIN]), 64'd0);
      check("midreset out_block", out_block[MAIN], 64'd0);
      @(negedge clk);
      reset = 1'b0;
      still_low = 1'b1;
      repeat (70) begin
         @(negedge clk);
         if (out_valid[MAIN]) still_low = 1'b0;
      end
      check("midreset no spurious output", 64'(still_low), 64'd1);
      run_block(MAIN, 1'b0, 64'h0, 128'h0, res, res_mode, lat);
      check("after reset block", res, ZERO_CT);
      check("after reset latency", 64'(lat), 64'd64);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tea_block_engine.md
Name: tea_block_engine

Overview:
- Parametrised TEA block-cipher engine with a valid/ready streaming interface.
- Each accepted 64-bit block is encrypted or decrypted under its own 128-bit key, selected per block by a mode bit.
- Round count is a parameter.
- Replaces switch-driven, one-value-at-a-time cipher control: a host FSM or switch/HEX front end feeds blocks and drains results through the handshakes.

Parameters:
- ROUNDS, 32, number of full Feistel cycles (each cycle is two half-rounds); legal range 1..64.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input block offered
- in_ready  out  1  engine can accept a block (high only in IDLE)
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept
- in_block  in  64  v0 = [63:32], v1 = [31:0]
- in_key  in  128  k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0]
- out_valid  out  1  result available
- out_ready  in  1  downstream takes result
- out_block  out  64  result, same packing as in_block
- out_mode  out  1  mode the result was produced with
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_block = 0; out_mode = 0.
  - Round counter, sum, v0/v1 and key registers all cleared.
- Reset mid-operation: the in-flight block is discarded, with no output. After reset releases, the first edge can accept a new block.
- All arithmetic is 32-bit, modulo 2^32. Shifts are logical.
- F(x, s, ka, kb) = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb). Additions bind before XOR, as written.
- Decrypt initial sum: SUM_INIT = (DELTA * ROUNDS) mod 2^32, a localparam. For ROUNDS = 32 this is 32'hC6EF3720.
- FSM states: IDLE, H0, H1, DONE.
- IDLE:
  - On in_valid & in_ready, latch block, key and mode.
  - Encrypt: sum = DELTA.
  - Decrypt: sum = SUM_INIT.
  - Clear the round counter and go to H0.
- H0:
  - Encrypt: v0 += F(v1, sum, k0, k1).
  - Decrypt: v1 -= F(v0, sum, k2, k3).
  - Go to H1.
- H1:
  - Encrypt: v1 += F(v0_new, sum, k2, k3); sum += DELTA.
  - Decrypt: v0 -= F(v1_new, sum, k0, k1); sum -= DELTA.
  - Increment the round counter.
  - If the counter reaches ROUNDS, go to DONE and load out_block/out_mode. Otherwise return to H0.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - On out_ready, go to IDLE and drop out_valid.
  - out_block and out_mode hold their values until the next result is loaded.
  - A new input cannot be accepted in the same cycle as the output handshake.
- Latency: out_valid rises exactly 2*ROUNDS clock edges after the accept edge (64 for the default). Throughput is one block per 2*ROUNDS+2 cycles when out_ready is held high.
- Back-pressure: out_ready low holds DONE indefinitely, with no change to out_block.
- Input stability: in_block, in_key and in_mode are ignored whenever no accept occurs. Changing them after the accept edge has no effect.
- Round counter width is $clog2(ROUNDS+1). It never wraps within a block.

Decomposition:
- Shared package tea_pkg holds:
  - DELTA default and the mode encoding (MODE_ENC = 0, MODE_DEC = 1).
  - State enum {IDLE, H0, H1, DONE}.
  - A pure function tea_f(x, s, ka, kb) returning 32 bits.
- Optional sub-module tea_half_round (combinational):
  - Inputs: v_src, v_dst, sum, ka, kb, mode.
  - Output: v_dst_next.
  - Instantiated once and muxed between H0 and H1.

Test Plan:
- Encrypt vector: ROUNDS = 32, key = 0, block = 0, encrypt → out_block = 64'h41EA3A0A_94BAA940, out_mode = 0, out_valid at 64 edges after accept.
- Decrypt vector: key = 0, block = 64'h41EA3A0A_94BAA940, decrypt → out_block = 0, out_mode = 1.
- Round-trip sweep: ROUNDS ∈ {1, 8, 32, 64}, 200 random keys/blocks, encrypt then decrypt → original block is recovered every time. SUM_INIT for ROUNDS = 64 is 32'h8DDE6E40.
- Back-pressure: hold out_ready = 0 for 10 cycles in DONE → out_valid stays 1, out_block stable, in_ready = 0, extra in_valid is ignored. Release → one transfer, then in_ready = 1.
- Reset mid-op: assert reset asynchronously during round 5 → out_valid = 0 and in_ready = 1 immediately, with no spurious output. The next block (key = 0, block = 0, encrypt) gives 64'h41EA3A0A_94BAA940.
- Input stability: change in_block/in_key on the cycle after accept → result matches the originally latched values.
